// File: rtl/cascade_counter.sv
// Cascaded multi-digit up/down counter with per-digit programmable maxima,
// single-cycle ripple between digits, registered carry/wrap pulses and a lap capture register.
module cascade_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            up,
    input  logic                            clear,
    input  logic                            load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   load_val,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   max_vals,
    input  logic                            lap,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   digits,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   lap_digits,
    output logic [NUM_DIGITS-1:0]           digit_carry,
    output logic                            wrap
);

    localparam int TOTAL_W = NUM_DIGITS * DIGIT_W;
    localparam logic [DIGIT_W-1:0] DIGIT_ZERO = {DIGIT_W{1'b0}};
    localparam logic [DIGIT_W-1:0] DIGIT_ONE  = {{(DIGIT_W-1){1'b0}}, 1'b1};

    logic [TOTAL_W-1:0]    digits_q;
    logic [TOTAL_W-1:0]    digits_d;
    logic [TOTAL_W-1:0]    lap_q;
    logic [TOTAL_W-1:0]    lap_d;
    logic [NUM_DIGITS-1:0] carry_q;
    logic [NUM_DIGITS-1:0] carry_d;
    logic                  wrap_q;
    logic                  wrap_d;

    logic [TOTAL_W-1:0]    stepped_s;
    logic [NUM_DIGITS-1:0] at_limit_s;
    logic [NUM_DIGITS-1:0] step_en_s;

    // A digit wraps up when at or above its max (covers loaded out-of-range values), down at zero.
    function automatic logic digit_at_limit(
        input logic [DIGIT_W-1:0] cur,
        input logic [DIGIT_W-1:0] mx,
        input logic               dir_up
    );
        logic lim;
        if (dir_up) begin
            lim = (cur >= mx);
        end else begin
            lim = (cur == DIGIT_ZERO);
        end
        return lim;
    endfunction

    function automatic logic [DIGIT_W-1:0] digit_step(
        input logic [DIGIT_W-1:0] cur,
        input logic [DIGIT_W-1:0] mx,
        input logic               dir_up,
        input logic               lim
    );
        logic [DIGIT_W-1:0] nxt;
        case ({dir_up, lim})
            2'b11:   nxt = DIGIT_ZERO;
            2'b10:   nxt = cur + DIGIT_ONE;
            2'b01:   nxt = mx;
            2'b00:   nxt = cur - DIGIT_ONE;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Per-digit limit detection, stepped value and ripple enable chain.
    always_comb begin
        stepped_s  = digits_q;
        at_limit_s = {NUM_DIGITS{1'b0}};
        step_en_s  = {NUM_DIGITS{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            at_limit_s[k] = digit_at_limit(digits_q[k*DIGIT_W +: DIGIT_W],
                                           max_vals[k*DIGIT_W +: DIGIT_W], up);
            stepped_s[k*DIGIT_W +: DIGIT_W] = digit_step(digits_q[k*DIGIT_W +: DIGIT_W],
                                                         max_vals[k*DIGIT_W +: DIGIT_W],
                                                         up, at_limit_s[k]);
            if (k == 0) begin
                step_en_s[k] = 1'b1;
            end else begin
                step_en_s[k] = step_en_s[k-1] & at_limit_s[k-1];
            end
        end
    end

    // Next-state selection: clear beats load beats enable; only counting raises carries.
    always_comb begin
        digits_d = digits_q;
        carry_d  = {NUM_DIGITS{1'b0}};
        if (clear) begin
            digits_d = {TOTAL_W{1'b0}};
        end else if (load) begin
            digits_d = load_val;
        end else if (enable) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (step_en_s[k]) begin
                    digits_d[k*DIGIT_W +: DIGIT_W] = stepped_s[k*DIGIT_W +: DIGIT_W];
                    carry_d[k] = at_limit_s[k];
                end else begin
                    digits_d[k*DIGIT_W +: DIGIT_W] = digits_q[k*DIGIT_W +: DIGIT_W];
                    carry_d[k] = 1'b0;
                end
            end
        end else begin
            digits_d = digits_q;
        end
        wrap_d = carry_d[NUM_DIGITS-1];
    end

    // Lap snapshots the pre-update count regardless of clear/load/enable.
    always_comb begin
        if (lap) begin
            lap_d = digits_q;
        end else begin
            lap_d = lap_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q <= {TOTAL_W{1'b0}};
            lap_q    <= {TOTAL_W{1'b0}};
            carry_q  <= {NUM_DIGITS{1'b0}};
            wrap_q   <= 1'b0;
        end else begin
            digits_q <= digits_d;
            lap_q    <= lap_d;
            carry_q  <= carry_d;
            wrap_q   <= wrap_d;
        end
    end

    assign digits      = digits_q;
    assign lap_digits  = lap_q;
    assign digit_carry = carry_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Self-checking bench for cascade_counter: directed scenarios plus randomized traffic
// compared against a digit-array reference model.
module tb_cascade_counter;

    logic        clk = 1'b0;
    logic        reset, enable, up, clear, load, lap;
    logic [15:0] load_val, max_vals;
    logic [15:0] digits, lap_digits;
    logic [3:0]  digit_carry;
    logic        wrap;

    int errors = 0;
    int checks = 0;

    // reference model state
    int md[4];
    int ml[4];
    int mc[4];
    int mw;

    cascade_counter #(.NUM_DIGITS(4), .DIGIT_W(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_val(load_val), .max_vals(max_vals), .lap(lap),
        .digits(digits), .lap_digits(lap_digits), .digit_carry(digit_carry), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pack4(input int a[4]);
        logic [15:0] v;
        for (int k = 0; k < 4; k++) v[k*4 +: 4] = a[k][3:0];
        return v;
    endfunction

    function automatic logic [3:0] packc();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (mc[k] != 0);
        return v;
    endfunction

    // Apply the counter rules to the model for one clock edge.
    task automatic model_step();
        int mx[4];
        int prop;
        int lim;
        for (int k = 0; k < 4; k++) begin
            mx[k] = int'(max_vals[k*4 +: 4]);
            mc[k] = 0;
        end
        mw = 0;
        if (reset) begin
            for (int k = 0; k < 4; k++) begin md[k] = 0; ml[k] = 0; end
        end else begin
            if (lap) for (int k = 0; k < 4; k++) ml[k] = md[k];
            if (clear) begin
                for (int k = 0; k < 4; k++) md[k] = 0;
            end else if (load) begin
                for (int k = 0; k < 4; k++) md[k] = int'(load_val[k*4 +: 4]);
            end else if (enable) begin
                prop = 1;
                for (int k = 0; k < 4; k++) begin
                    if (prop != 0) begin
                        if (up) begin
                            lim = (md[k] >= mx[k]) ? 1 : 0;
                            md[k] = (lim != 0) ? 0 : (md[k] + 1) % 16;
                        end else begin
                            lim = (md[k] == 0) ? 1 : 0;
                            md[k] = (lim != 0) ? mx[k] : md[k] - 1;
                        end
                        mc[k] = lim;
                        prop  = lim;
                    end
                end
                mw = mc[3];
            end
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic u, input logic cl,
                         input logic ld, input logic lp, input logic [15:0] lv);
        reset = r; enable = en; up = u; clear = cl; load = ld; lap = lp; load_val = lv;
        model_step();
        @(posedge clk);
        #1;
        reset = 1'b0; enable = 1'b0; clear = 1'b0; load = 1'b0; lap = 1'b0;
    endtask

    task automatic test_reset();
        max_vals = 16'h5959;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234);
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits act=%h exp=0000", digits); end
        checks++; if (lap_digits !== 16'h0000) begin errors++; $display("FAIL reset_lap act=%h exp=0000", lap_digits); end
        checks++; if (digit_carry !== 4'b0000 || wrap !== 1'b0) begin errors++; $display("FAIL reset_pulses act=%b/%b exp=0000/0", digit_carry, wrap); end
    endtask

    task automatic test_partial_ripple();
        max_vals = 16'h5959;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0959);
        checks++; if (digits !== 16'h0959 || digit_carry !== 4'b0000) begin errors++; $display("FAIL load_0959 act=%h/%b exp=0959/0000", digits, digit_carry); end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (digits !== 16'h1000) begin errors++; $display("FAIL ripple_digits act=%h exp=1000", digits); end
        checks++; if (digit_carry !== 4'b0111 || wrap !== 1'b0) begin errors++; $display("FAIL ripple_carry act=%b/%b exp=0111/0", digit_carry, wrap); end
    endtask

    task automatic test_full_wrap();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5959);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL wrap_digits act=%h exp=0000", digits); end
        checks++; if (digit_carry !== 4'b1111 || wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse act=%b/%b exp=1111/1", digit_carry, wrap); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (digits !== 16'h0000 || digit_carry !== 4'b0000 || wrap !== 1'b0) begin errors++; $display("FAIL wrap_one_cycle act=%h/%b/%b exp=0000/0000/0", digits, digit_carry, wrap); end
    endtask

    task automatic test_borrow();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (digits !== 16'h5959 || wrap !== 1'b1) begin errors++; $display("FAIL borrow_wrap act=%h/%b exp=5959/1", digits, wrap); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (digits !== 16'h5958 || wrap !== 1'b0 || digit_carry !== 4'b0000) begin errors++; $display("FAIL borrow_step act=%h/%b/%b exp=5958/0/0000", digits, wrap, digit_carry); end
        max_vals = 16'hFFFF;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (digits !== 16'hFFFF || wrap !== 1'b1) begin errors++; $display("FAIL binary_borrow act=%h/%b exp=ffff/1", digits, wrap); end
        max_vals = 16'h5959;
    endtask

    task automatic test_priority();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0123);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0456);
        checks++; if (digits !== 16'h0000 || digit_carry !== 4'b0000) begin errors++; $display("FAIL clear_prio act=%h/%b exp=0000/0000", digits, digit_carry); end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0456);
        checks++; if (digits !== 16'h0456 || digit_carry !== 4'b0000 || wrap !== 1'b0) begin errors++; $display("FAIL load_prio act=%h/%b exp=0456/0000", digits, digit_carry); end
    endtask

    task automatic test_lap();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0042);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        checks++; if (lap_digits !== 16'h0042 || digits !== 16'h0043) begin errors++; $display("FAIL lap_capture act=%h/%h exp=0042/0043", lap_digits, digits); end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (lap_digits !== 16'h0042 || digits !== 16'h0044) begin errors++; $display("FAIL lap_hold act=%h/%h exp=0042/0044", lap_digits, digits); end
    endtask

    task automatic test_reset_mid_count();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0959);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        checks++; if (digits !== 16'h0000 || lap_digits !== 16'h0000 || digit_carry !== 4'b0000 || wrap !== 1'b0) begin
            errors++; $display("FAIL reset_mid act=%h/%h/%b/%b exp=0000/0000/0000/0", digits, lap_digits, digit_carry, wrap);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (digits !== 16'h0001) begin errors++; $display("FAIL after_reset act=%h exp=0001", digits); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h000A);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (digits !== 16'h0010 || digit_carry !== 4'b0001) begin errors++; $display("FAIL overmax_up act=%h/%b exp=0010/0001", digits, digit_carry); end
    endtask

    task automatic test_random();
        logic u;
        u = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < 4; k++)
                    max_vals[k*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 15) == 0) u = ~u;
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8), u,
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) == 0), 16'($urandom));
            checks++; if (digits !== pack4(md)) begin errors++; $display("FAIL rnd_digits cyc=%0d act=%h exp=%h", i, digits, pack4(md)); end
            checks++; if (lap_digits !== pack4(ml)) begin errors++; $display("FAIL rnd_lap cyc=%0d act=%h exp=%h", i, lap_digits, pack4(ml)); end
            checks++; if (digit_carry !== packc()) begin errors++; $display("FAIL rnd_carry cyc=%0d act=%b exp=%b", i, digit_carry, packc()); end
            checks++; if (wrap !== (mw != 0)) begin errors++; $display("FAIL rnd_wrap cyc=%0d act=%b exp=%0d", i, wrap, mw); end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; lap = 1'b0;
        load_val = 16'h0000; max_vals = 16'h5959;
        for (int k = 0; k < 4; k++) begin md[k] = 0; ml[k] = 0; mc[k] = 0; end
        mw = 0;
        @(negedge clk);
        test_reset();
        test_partial_ripple();
        test_full_wrap();
        test_borrow();
        test_priority();
        test_lap();
        test_reset_mid_count();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
